// File: rtl/simon_flash_driver_if.sv
// Request/status bundle between the Simon game FSM (master) and the LED/tone flash driver (slave).
interface simon_flash_driver_if;
  logic       start;
  logic [1:0] color;
  logic       cancel;
  logic       mute;
  logic       ready;
  logic       busy;
  logic [3:0] led;
  logic       tone;
  logic       done;

  modport master (
    output start, color, cancel, mute,
    input  ready, busy, led, tone, done
  );

  modport slave (
    input  start, color, cancel, mute,
    output ready, busy, led, tone, done
  );
endinterface

// File: rtl/simon_flash_driver.sv
// Turns a one-cycle colour request into a timed LED flash with a per-colour square-wave tone,
// followed by a dark gap, using a tick prescaler for the human-scale timing.
module simon_flash_driver #(
  parameter int TICK_CYCLES = 1000000,
  parameter int ON_TICKS    = 50,
  parameter int OFF_TICKS   = 25,
  parameter int TONE_HALF0  = 120482,
  parameter int TONE_HALF1  = 161290,
  parameter int TONE_HALF2  = 198413,
  parameter int TONE_HALF3  = 239234
) (
  input logic                  i_clk,
  input logic                  i_rst,
  simon_flash_driver_if.slave  io_flash
);
  localparam int TICK_MAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int HALF_A    = (TONE_HALF0 > TONE_HALF1) ? TONE_HALF0 : TONE_HALF1;
  localparam int HALF_B    = (TONE_HALF2 > TONE_HALF3) ? TONE_HALF2 : TONE_HALF3;
  localparam int HALF_MAX  = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int PW        = $clog2(TICK_CYCLES);
  localparam int CW        = $clog2(TICK_MAX + 1);
  localparam int HW        = ($clog2(HALF_MAX) < 1) ? 1 : $clog2(HALF_MAX);
  localparam logic [PW-1:0] P_RELOAD = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_tickCnt;
  logic [HW-1:0] r_toneCnt;
  logic [1:0]    r_color;
  logic [3:0]    r_led;
  logic          r_tone;
  logic          r_tonePhase;
  logic          r_done;

  logic w_accept;
  logic w_tick;
  logic w_lastTick;
  logic w_toneToggle;
  logic w_phaseNext;

  // Counter preload is half-period minus one so the first toggle lands HALFn cycles after acceptance.
  function automatic logic [HW-1:0] halfReload(input logic [1:0] c);
    case (c)
      2'd0:    halfReload = HW'(TONE_HALF0 - 1);
      2'd1:    halfReload = HW'(TONE_HALF1 - 1);
      2'd2:    halfReload = HW'(TONE_HALF2 - 1);
      default: halfReload = HW'(TONE_HALF3 - 1);
    endcase
  endfunction

  assign w_accept     = io_flash.start && (r_state == S_IDLE) && !io_flash.cancel;
  assign w_tick       = (r_presc == '0);
  assign w_lastTick   = w_tick && (r_tickCnt <= CW'(1));
  assign w_toneToggle = (r_toneCnt == '0);
  assign w_phaseNext  = w_toneToggle ? ~r_tonePhase : r_tonePhase;

  assign io_flash.ready = (r_state == S_IDLE);
  assign io_flash.busy  = (r_state != S_IDLE);
  assign io_flash.led   = r_led;
  assign io_flash.tone  = r_tone;
  assign io_flash.done  = r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_tickCnt   <= '0;
      r_toneCnt   <= '0;
      r_color     <= '0;
      r_led       <= '0;
      r_tone      <= 1'b0;
      r_tonePhase <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (io_flash.cancel && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_presc     <= '0;
        r_tickCnt   <= '0;
        r_toneCnt   <= '0;
        r_led       <= '0;
        r_tone      <= 1'b0;
        r_tonePhase <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state     <= S_ON;
              r_color     <= io_flash.color;
              r_led       <= 4'b0001 << io_flash.color;
              r_presc     <= P_RELOAD;
              r_tickCnt   <= CW'(ON_TICKS);
              r_toneCnt   <= halfReload(io_flash.color);
              r_tonePhase <= 1'b0;
              r_tone      <= 1'b0;
            end
          end
          S_ON: begin
            r_presc <= w_tick ? P_RELOAD : r_presc - PW'(1);
            if (w_tick && (r_tickCnt != '0)) r_tickCnt <= r_tickCnt - CW'(1);
            if (w_lastTick) begin
              r_led       <= '0;
              r_tone      <= 1'b0;
              r_tonePhase <= 1'b0;
              r_toneCnt   <= '0;
              // A zero-length gap skips GAP and completes straight from ON.
              if (OFF_TICKS == 0) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_presc <= '0;
              end else begin
                r_state   <= S_GAP;
                r_tickCnt <= CW'(OFF_TICKS);
              end
            end else begin
              r_toneCnt   <= w_toneToggle ? halfReload(r_color) : r_toneCnt - HW'(1);
              r_tonePhase <= w_phaseNext;
              r_tone      <= w_phaseNext && !io_flash.mute;
            end
          end
          S_GAP: begin
            r_presc <= w_tick ? P_RELOAD : r_presc - PW'(1);
            if (w_tick && (r_tickCnt != '0)) r_tickCnt <= r_tickCnt - CW'(1);
            if (w_lastTick) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_presc <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
